dmem_arbiter: RTL and testbench

Shares the single-port data memory (12-bit word address, 32-bit data, one-cycle registered read) between the pipeline memory stage (requester A) and an external port (requester B, e.g. loader/IO/debug). A has fixed priority. A streak counter bounds B's wait by forcing one B grant and stalling the pipeline for that cycle. Read data is routed back to its owner using a tag pipeline that matches memory read latency. Sits between the memory stage and the dmem instance and drives `address_dmem`/`d_dmem`/`wren`.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: pipeline (A) has priority,
// external port (B) gets a forced slot after MAX_STREAK consecutive A wins.
module dmem_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int RD_LAT     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    input  logic        a_wren,
    input  logic [11:0] a_addr,
    input  logic [31:0] a_data,
    output logic [31:0] a_q,
    output logic        a_rvalid,
    output logic        stall_pipe,
    input  logic        b_req,
    input  logic        b_wren,
    input  logic [11:0] b_addr,
    input  logic [31:0] b_data,
    output logic        b_gnt,
    output logic [31:0] b_q,
    output logic        b_rvalid,
    output logic [11:0] address_dmem,
    output logic [31:0] d_dmem,
    output logic        wren,
    input  logic [31:0] q_dmem,
    output logic [15:0] steal_count
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0]        streak_q, streak_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;
    logic [31:0]       b_q_q, b_q_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [15:0]       steal_q, steal_d;

    logic force_b, gnt_a, gnt_b, rd_issue;
    logic last_vld, last_own;

    always_comb begin
        force_b  = b_req && (streak_q == STREAK_MAX);
        gnt_b    = force_b || (b_req && !a_valid);
        gnt_a    = a_valid && !force_b;
        rd_issue = (gnt_a && !a_wren) || (gnt_b && !b_wren);
        last_vld = tag_vld_q[RD_LAT-1];
        last_own = tag_own_q[RD_LAT-1];
    end

    always_comb begin
        address_dmem = 12'd0;
        d_dmem       = 32'd0;
        wren         = 1'b0;
        if (gnt_b) begin
            address_dmem = b_addr;
            d_dmem       = b_data;
            wren         = b_wren;
        end else if (gnt_a) begin
            address_dmem = a_addr;
            d_dmem       = a_data;
            wren         = a_wren;
        end
    end

    always_comb begin
        // Streak only grows while B is actually waiting behind A.
        streak_d = streak_q;
        if (gnt_b || !b_req) begin
            streak_d = 4'd0;
        end else if (gnt_a && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end

        // Owner bit: 1 = B. Writes enter as invalid bubbles.
        tag_vld_d    = tag_vld_q;
        tag_own_d    = tag_own_q;
        tag_vld_d[0] = rd_issue;
        tag_own_d[0] = gnt_b;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end

        b_rvalid_d = last_vld && last_own;
        b_q_d      = (last_vld && last_own) ? q_dmem : b_q_q;

        steal_d = steal_q;
        if (force_b && steal_q != 16'hFFFF) begin
            steal_d = steal_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak_q   <= 4'd0;
            tag_vld_q  <= '0;
            tag_own_q  <= '0;
            b_q_q      <= 32'd0;
            b_rvalid_q <= 1'b0;
            steal_q    <= 16'd0;
        end else begin
            streak_q   <= streak_d;
            tag_vld_q  <= tag_vld_d;
            tag_own_q  <= tag_own_d;
            b_q_q      <= b_q_d;
            b_rvalid_q <= b_rvalid_d;
            steal_q    <= steal_d;
        end
    end

    assign a_q         = q_dmem;
    assign a_rvalid    = last_vld && !last_own;
    assign stall_pipe  = a_valid && gnt_b;
    assign b_gnt       = gnt_b;
    assign b_q         = b_q_q;
    assign b_rvalid    = b_rvalid_q;
    assign steal_count = steal_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share one
// stimulus stream, each with its own memory model; reads are scored through queues.
module tb_dmem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, a_wren, b_req, b_wren;
    logic [11:0] a_addr, b_addr;
    logic [31:0] a_data, b_data;

    logic [31:0] a_q1, b_q1, d1, q1, a_q2, b_q2, d2, q2, q2a;
    logic        a_rvalid1, stall1, b_gnt1, b_rvalid1, wren1;
    logic        a_rvalid2, stall2, b_gnt2, b_rvalid2, wren2;
    logic [11:0] addr1, addr2;
    logic [15:0] steal1, steal2;

    logic [31:0] mem1 [4096];
    logic [31:0] mem2 [4096];
    logic [31:0] shadow [4096];

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_t;
    sb_t sb [4][$];

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_arbiter #(.MAX_STREAK(4), .RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data),
        .a_q(a_q1), .a_rvalid(a_rvalid1), .stall_pipe(stall1),
        .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_data(b_data),
        .b_gnt(b_gnt1), .b_q(b_q1), .b_rvalid(b_rvalid1),
        .address_dmem(addr1), .d_dmem(d1), .wren(wren1), .q_dmem(q1),
        .steal_count(steal1)
    );

    dmem_arbiter #(.MAX_STREAK(4), .RD_LAT(2)) dut2 (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data),
        .a_q(a_q2), .a_rvalid(a_rvalid2), .stall_pipe(stall2),
        .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_data(b_data),
        .b_gnt(b_gnt2), .b_q(b_q2), .b_rvalid(b_rvalid2),
        .address_dmem(addr2), .d_dmem(d2), .wren(wren2), .q_dmem(q2),
        .steal_count(steal2)
    );

    // Memory models: one-cycle and two-cycle registered read.
    always @(posedge clock) begin
        if (wren1) mem1[addr1] <= d1;
        q1 <= mem1[addr1];
    end

    always @(posedge clock) begin
        if (wren2) mem2[addr2] <= d2;
        q2a <= mem2[addr2];
        q2  <= q2a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                        input logic [31:0] exp);
        chk({tag, "_lat1"}, o1, exp);
        chk({tag, "_lat2"}, o2, exp);
    endtask

    task automatic mon(input int i, input string tag, input logic rv, input logic [31:0] d);
        sb_t  e;
        logic exp_rv;
        while (sb[i].size() != 0 && sb[i][0].due < cyc) void'(sb[i].pop_front());
        exp_rv = (sb[i].size() != 0) && (sb[i][0].due == cyc);
        chk({tag, "_rvalid"}, 32'(rv), 32'(exp_rv));
        if (rv && exp_rv) begin
            e = sb[i].pop_front();
            chk({tag, "_data"}, d, e.data);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon(0, "a_lat1", a_rvalid1, a_q1);
            mon(1, "b_lat1", b_rvalid1, b_q1);
            mon(2, "a_lat2", a_rvalid2, a_q2);
            mon(3, "b_lat2", b_rvalid2, b_q2);
        end
    end

    task automatic drv(input logic av, input logic aw, input logic [11:0] aa,
                       input logic [31:0] ad, input logic br, input logic bw,
                       input logic [11:0] ba, input logic [31:0] bd);
        a_valid = av; a_wren = aw; a_addr = aa; a_data = ad;
        b_req   = br; b_wren = bw; b_addr = ba; b_data = bd;
    endtask

    // One cycle with the grant the bench expects; everything else follows from it.
    task automatic st(input logic exp_gb, input string tag);
        logic        exp_ga, ew;
        logic [11:0] ea;
        logic [31:0] ed;
        sb_t         e;
        @(negedge clock);
        exp_ga = a_valid && !exp_gb;
        ea = exp_gb ? b_addr : (exp_ga ? a_addr : 12'd0);
        ed = exp_gb ? b_data : (exp_ga ? a_data : 32'd0);
        ew = exp_gb ? b_wren : (exp_ga ? a_wren : 1'b0);
        chk2({tag, "_bgnt"},  32'(b_gnt1), 32'(b_gnt2), 32'(exp_gb));
        chk2({tag, "_stall"}, 32'(stall1), 32'(stall2), 32'(a_valid && exp_gb));
        chk2({tag, "_addr"},  32'(addr1),  32'(addr2),  32'(ea));
        chk2({tag, "_wdata"}, d1, d2, ed);
        chk2({tag, "_wren"},  32'(wren1),  32'(wren2),  32'(ew));
        if (ew) begin
            shadow[ea] = ed;
        end else if (exp_gb || exp_ga) begin
            e.data = shadow[ea];
            e.due  = cyc + 1 + (exp_gb ? 1 : 0);
            sb[exp_gb ? 1 : 0].push_back(e);
            e.due  = cyc + 2 + (exp_gb ? 1 : 0);
            sb[exp_gb ? 3 : 2].push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0);
        for (int k = 0; k < n; k++) st(1'b0, "idle");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = 32'd0;
        reset = 1'b1;
        drv(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk2("rst_brvalid", 32'(b_rvalid1), 32'(b_rvalid2), 32'd0);
        chk2("rst_arvalid", 32'(a_rvalid1), 32'(a_rvalid2), 32'd0);
        chk2("rst_steal",   32'(steal1),    32'(steal2),    32'd0);
        chk2("rst_wren",    32'(wren1),     32'(wren2),     32'd0);
        chk2("rst_bq",      b_q1,           b_q2,           32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // A only: stores then a read of the stored word
        drv(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'd0, 32'd0); st(1'b0, "a_st010");
        drv(1, 1, 12'h001, 32'h00000011, 0, 0, 12'd0, 32'd0); st(1'b0, "a_st001");
        drv(1, 1, 12'h002, 32'h00000022, 0, 0, 12'd0, 32'd0); st(1'b0, "a_st002");
        drv(1, 0, 12'h010, 32'd0,        0, 0, 12'd0, 32'd0); st(1'b0, "a_rd010");
        idle(3);

        // B only: read, write, read back
        drv(0, 0, 12'd0, 32'd0, 1, 0, 12'h010, 32'd0);        st(1'b1, "b_rd010");
        drv(0, 0, 12'd0, 32'd0, 1, 1, 12'h020, 32'hCAFEF00D); st(1'b1, "b_wr020");
        drv(0, 0, 12'd0, 32'd0, 1, 0, 12'h020, 32'd0);        st(1'b1, "b_rd020");
        idle(4);
        chk2("b_only_steal", 32'(steal1), 32'(steal2), 32'd0);

        // Starvation: both held, B forced every fifth cycle
        drv(1, 0, 12'h001, 32'd0, 1, 0, 12'h002, 32'd0);
        for (int p = 0; p < 2; p++) begin
            repeat (4) st(1'b0, "starve_a");
            st(1'b1, "starve_force");
            chk2("starve_steal", 32'(steal1), 32'(steal2), 32'(p + 1));
        end
        idle(4);

        // Interleaved reads: A reads 0x001, then forced B read of 0x002
        drv(1, 0, 12'h010, 32'd0, 1, 0, 12'h002, 32'd0);
        repeat (3) st(1'b0, "il_pre");
        drv(1, 0, 12'h001, 32'd0, 1, 0, 12'h002, 32'd0);
        st(1'b0, "il_a001");
        st(1'b1, "il_b002");
        idle(4);
        chk2("il_steal", 32'(steal1), 32'(steal2), 32'd3);

        // Streak clear: B withdraws after 3 A grants, then needs a full 4 again
        drv(1, 0, 12'h010, 32'd0, 1, 0, 12'h001, 32'd0);
        repeat (3) st(1'b0, "sc_pre");
        drv(1, 0, 12'h010, 32'd0, 0, 0, 12'h001, 32'd0);
        st(1'b0, "sc_drop");
        drv(1, 0, 12'h002, 32'd0, 1, 0, 12'h001, 32'd0);
        repeat (4) st(1'b0, "sc_a");
        st(1'b1, "sc_force");
        idle(4);
        chk2("sc_steal", 32'(steal1), 32'(steal2), 32'd4);

        // Reset with a B read in flight: the read must never be reported
        drv(0, 0, 12'd0, 32'd0, 1, 0, 12'h010, 32'd0);
        st(1'b1, "rst_b_rd");
        reset = 1'b1;
        drv(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0);
        for (int i = 0; i < 4; i++) sb[i].delete();
        @(negedge clock);
        chk2("rst_mid_brvalid", 32'(b_rvalid1), 32'(b_rvalid2), 32'd0);
        chk2("rst_mid_steal",   32'(steal1),    32'(steal2),    32'd0);
        chk2("rst_mid_wren",    32'(wren1),     32'(wren2),     32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk2("post_rst_brvalid", 32'(b_rvalid1), 32'(b_rvalid2), 32'd0);
        chk2("post_rst_arvalid", 32'(a_rvalid1), 32'(a_rvalid2), 32'd0);
        @(posedge clock);
        #1;
        drv(1, 0, 12'h010, 32'd0, 0, 0, 12'd0, 32'd0); st(1'b0, "post_rst_a_rd");
        idle(4);

        for (int i = 0; i < 4; i++) chk($sformatf("sb%0d_drained", i), 32'(sb[i].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
